// File: rtl/decode_cycle.sv
// RISC-V decode stage: register file with write-through bypass, control/immediate
// decode, and the D->E pipeline register with flush-to-bubble on the controls.
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  RdE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
    result_src_e result_src;
    alu_op_e     alu_control;
  } ctrl_t;

  // Instruction fields
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_funct7_5;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;

  assign w_opcode   = InstrD[6:0];
  assign w_funct3   = InstrD[14:12];
  assign w_funct7_5 = InstrD[30];
  assign w_rs1      = InstrD[19:15];
  assign w_rs2      = InstrD[24:20];
  assign w_rd       = InstrD[11:7];

  ctrl_t       w_ctrl;
  imm_sel_e    w_imm_sel;
  logic        w_alu_by_funct;
  logic [31:0] w_imm_ext;

  // NOTE: every signal written here is given a default first so no path leaves it
  // unassigned; that is what keeps combinational decode from inferring latches.
  always_comb begin
    w_ctrl         = '0;
    w_imm_sel      = IMM_NONE;
    w_alu_by_funct = 1'b0;
    unique case (w_opcode)
      OP_R: begin
        w_ctrl.reg_write = 1'b1;
        w_alu_by_funct   = 1'b1;
      end
      OP_I: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_imm_sel        = IMM_I;
        w_alu_by_funct   = 1'b1;
      end
      OP_LW: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_MEM;
        w_imm_sel         = IMM_I;
      end
      OP_SW: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_imm_sel        = IMM_S;
      end
      OP_BEQ: begin
        w_ctrl.branch      = 1'b1;
        w_ctrl.alu_control = ALU_SUB;
        w_imm_sel          = IMM_B;
      end
      OP_JAL: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.jump       = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_imm_sel         = IMM_J;
      end
      default: ;
    endcase

    // Only R-type and I-ALU pick the operation from funct3; sub is R-type only
    if (w_alu_by_funct) begin
      unique case (w_funct3)
        3'b000:  w_ctrl.alu_control = (w_opcode == OP_R && w_funct7_5) ? ALU_SUB : ALU_ADD;
        3'b010:  w_ctrl.alu_control = ALU_SLT;
        3'b110:  w_ctrl.alu_control = ALU_OR;
        3'b111:  w_ctrl.alu_control = ALU_AND;
        default: w_ctrl.alu_control = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    w_imm_ext = '0;
    unique case (w_imm_sel)
      IMM_I:   w_imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   w_imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   w_imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                            InstrD[11:8], 1'b0};
      IMM_J:   w_imm_ext = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                            InstrD[30:21], 1'b0};
      default: w_imm_ext = '0;
    endcase
  end

  // Register file
  logic [31:0] r_regs [32];
  logic        w_wb_valid;

  assign w_wb_valid = RegWriteW && (RdW != 5'd0);

  // NOTE: this array is deliberately cleared by reset because architectural state
  // must read 0 afterwards; that forces flops rather than a RAM macro, which is
  // acceptable at 32 entries. Storage with no such requirement is left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wb_valid) begin
      r_regs[RdW] <= ResultW;
    end
  end

  // Same-cycle writeback is forwarded so decode never sees the stale value
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  always_comb begin
    if (w_rs1 == 5'd0)                     w_rd1 = '0;
    else if (w_wb_valid && RdW == w_rs1)   w_rd1 = ResultW;
    else                                   w_rd1 = r_regs[w_rs1];

    if (w_rs2 == 5'd0)                     w_rd2 = '0;
    else if (w_wb_valid && RdW == w_rs2)   w_rd2 = ResultW;
    else                                   w_rd2 = r_regs[w_rs2];
  end

  // D->E pipeline register
  ctrl_t       r_ctrl_e;
  logic [31:0] r_rd1_e;
  logic [31:0] r_rd2_e;
  logic [31:0] r_imm_e;
  logic [4:0]  r_rd_e;
  logic [31:0] r_pc_e;
  logic [31:0] r_pc4_e;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order or of other always_ff blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl_e <= '0;
      r_rd1_e  <= '0;
      r_rd2_e  <= '0;
      r_imm_e  <= '0;
      r_rd_e   <= '0;
      r_pc_e   <= '0;
      r_pc4_e  <= '0;
    end else begin
      r_ctrl_e <= w_ctrl;
      if (FlushE) begin
        r_ctrl_e.reg_write <= 1'b0;
        r_ctrl_e.mem_write <= 1'b0;
        r_ctrl_e.branch    <= 1'b0;
        r_ctrl_e.jump      <= 1'b0;
      end
      r_rd1_e <= w_rd1;
      r_rd2_e <= w_rd2;
      r_imm_e <= w_imm_ext;
      r_rd_e  <= w_rd;
      r_pc_e  <= PCD;
      r_pc4_e <= PCPlus4D;
    end
  end

  assign RegWriteE   = r_ctrl_e.reg_write;
  assign MemWriteE   = r_ctrl_e.mem_write;
  assign BranchE     = r_ctrl_e.branch;
  assign JumpE       = r_ctrl_e.jump;
  assign ALUSrcE     = r_ctrl_e.alu_src;
  assign ResultSrcE  = r_ctrl_e.result_src;
  assign ALUControlE = r_ctrl_e.alu_control;
  assign RD1E        = r_rd1_e;
  assign RD2E        = r_rd2_e;
  assign ImmExtE     = r_imm_e;
  assign RdE         = r_rd_e;
  assign PCE         = r_pc_e;
  assign PCPlus4E    = r_pc4_e;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed cases followed by random traffic
// compared against an instruction-level reference model of decode and the regfile.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RdW;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RdE(RdE), .PCE(PCE),
    .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] model_regs [32];

  typedef struct {
    bit          known;
    bit          is_jal;
    logic        rw, mw, br, jp, as;
    logic [1:0]  rsrc;
    logic [2:0]  alu;
    logic [31:0] imm, rd1, rd2, pc, pc4;
    logic [4:0]  rd;
  } exp_t;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (RegWriteW && RdW == a) return ResultW;
    return model_regs[a];
  endfunction

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic signed [31:0] s;
    logic [2:0] f3;
    s = ins;
    f3 = ins[14:12];
    e = '{default: '0};
    e.rd1 = model_read(ins[19:15]);
    e.rd2 = model_read(ins[24:20]);
    e.rd  = ins[11:7];
    e.pc  = PCD;
    e.pc4 = PCPlus4D;
    e.known = 1'b1;
    case (ins[6:0])
      7'h33, 7'h13: begin
        e.rw = 1;
        e.as = (ins[6:0] == 7'h13);
        e.imm = e.as ? 32'(s >>> 20) : 32'd0;
        if (f3 == 3'b010)      e.alu = 3'b101;
        else if (f3 == 3'b110) e.alu = 3'b011;
        else if (f3 == 3'b111) e.alu = 3'b010;
        else if (f3 == 3'b000 && !e.as && ins[30]) e.alu = 3'b001;
        else                   e.alu = 3'b000;
      end
      7'h03: begin e.rw = 1; e.as = 1; e.rsrc = 2'b01; e.imm = 32'(s >>> 20); end
      7'h23: begin
        e.mw = 1; e.as = 1;
        e.imm = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
      end
      7'h63: begin
        e.br = 1; e.alu = 3'b001;
        e.imm = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) |
                (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      end
      7'h6F: begin
        e.rw = 1; e.jp = 1; e.rsrc = 2'b10; e.is_jal = 1;
        e.imm = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) |
                (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      end
      default: e.known = 1'b0;
    endcase
    return e;
  endfunction

  // One decode cycle: drive at negedge, clock, then compare at the next negedge
  task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                      input logic wb_en, input logic [4:0] wb_rd,
                      input logic [31:0] wb_res, input logic flush);
    exp_t e;
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = wb_en; RdW = wb_rd; ResultW = wb_res; FlushE = flush;
    #1;
    e = model(ins);
    @(posedge clk);
    if (wb_en && wb_rd != 5'd0) model_regs[wb_rd] = wb_res;
    @(negedge clk);
    check("RegWriteE", 32'(RegWriteE), flush ? 32'd0 : 32'(e.rw));
    check("MemWriteE", 32'(MemWriteE), flush ? 32'd0 : 32'(e.mw));
    check("BranchE",   32'(BranchE),   flush ? 32'd0 : 32'(e.br));
    check("JumpE",     32'(JumpE),     flush ? 32'd0 : 32'(e.jp));
    if (!flush) begin
      check("RD1E", RD1E, e.rd1);
      check("RD2E", RD2E, e.rd2);
      check("RdE",  32'(RdE), 32'(e.rd));
      check("PCE",  PCE, e.pc);
      check("PCPlus4E", PCPlus4E, e.pc4);
      if (e.known) begin
        check("ResultSrcE",  32'(ResultSrcE),  32'(e.rsrc));
        check("ALUControlE", 32'(ALUControlE), 32'(e.alu));
        check("ImmExtE",     ImmExtE, e.imm);
        if (!e.is_jal) check("ALUSrcE", 32'(ALUSrcE), 32'(e.as));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {27'd0, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE}, 32'd0);
    check({tag, "_srcalu"}, {27'd0, ResultSrcE, ALUControlE}, 32'd0);
    check({tag, "_RD1E"}, RD1E, 32'd0);
    check({tag, "_RD2E"}, RD2E, 32'd0);
    check({tag, "_ImmExtE"}, ImmExtE, 32'd0);
    check({tag, "_RdE"}, 32'(RdE), 32'd0);
    check({tag, "_PCE"}, PCE, 32'd0);
    check({tag, "_PCPlus4E"}, PCPlus4E, 32'd0);
  endtask

  // Asynchronous reset pulse between edges with arbitrary inputs applied
  task automatic do_reset(input string tag);
    #2;
    InstrD = $urandom; PCD = $urandom; PCPlus4D = $urandom;
    RegWriteW = 1'b1; RdW = 5'($urandom_range(1, 31)); ResultW = $urandom;
    FlushE = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [2:0]  f3;
    int          k;
    ins = $urandom;
    k = $urandom_range(0, 6);
    case (k)
      0: ins[6:0] = 7'h33;
      1: ins[6:0] = 7'h13;
      2: ins[6:0] = 7'h03;
      3: ins[6:0] = 7'h23;
      4: ins[6:0] = 7'h63;
      5: ins[6:0] = 7'h6F;
      default: ;
    endcase
    case ($urandom_range(0, 4))
      0: f3 = 3'b000;
      1: f3 = 3'b010;
      2: f3 = 3'b110;
      3: f3 = 3'b111;
      default: f3 = 3'($urandom);
    endcase
    ins[14:12] = f3;
    return ins;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    rst = 1'b1;
    InstrD = $urandom; PCD = $urandom; PCPlus4D = $urandom;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0; FlushE = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_init");
    rst = 1'b0;

    // Directed cases
    step(32'h000281B3, 32'h0000_0100, 0, 5'd0, 32'd0, 0);          // add x3,x5,x0
    check("x5_after_reset", RD1E, 32'd0);
    step(32'h00500093, 32'h0000_0104, 0, 5'd0, 32'd0, 0);          // addi x1,x0,5
    check("addi_imm", ImmExtE, 32'd5);
    check("addi_alusrc", 32'(ALUSrcE), 32'd1);
    step(32'h000081B3, 32'h0000_0108, 1, 5'd1, 32'h0000_1234, 0);  // bypass x1
    check("bypass_rd1", RD1E, 32'h0000_1234);
    step(32'h000081B3, 32'h0000_010C, 0, 5'd0, 32'd0, 0);          // array now holds x1
    check("array_x1", RD1E, 32'h0000_1234);
    step(32'h000001B3, 32'h0000_0110, 1, 5'd0, 32'hFFFF_FFFF, 0);  // x0 write + read
    step(32'h000001B3, 32'h0000_0114, 0, 5'd0, 32'd0, 0);
    check("x0_rd1", RD1E, 32'd0);
    check("x0_rd2", RD2E, 32'd0);
    step(32'h0020A423, 32'h0000_0118, 0, 5'd0, 32'd0, 0);          // sw x2,8(x1)
    check("sw_imm", ImmExtE, 32'd8);
    step(32'hFE208EE3, 32'h0000_011C, 0, 5'd0, 32'd0, 0);          // beq x1,x2,-4
    check("beq_imm", ImmExtE, 32'hFFFF_FFFC);
    step(32'h008000EF, 32'h0000_0120, 1, 5'd2, 32'h0000_ABCD, 1);  // jal flushed + wb
    step(32'h008000EF, 32'h0000_0124, 0, 5'd0, 32'd0, 0);          // jal x1,8
    check("jal_imm", ImmExtE, 32'd8);
    check("jal_rsrc", 32'(ResultSrcE), 32'd2);
    step(32'h00208133, 32'h0000_0128, 0, 5'd0, 32'd0, 0);          // add x2,x1,x2
    check("wb_under_flush", RD2E, 32'h0000_ABCD);
    step(32'h40208133, 32'h0000_012C, 0, 5'd0, 32'd0, 0);          // sub x2,x1,x2
    step(32'h0000007F, 32'h0000_0130, 0, 5'd0, 32'd0, 0);          // unsupported opcode

    do_reset("reset_mid");
    step(32'h000081B3, 32'h0000_0200, 0, 5'd0, 32'd0, 0);
    check("x1_cleared", RD1E, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 131 == 70) do_reset("reset_rand");
      step(rand_instr(), $urandom, ($urandom_range(0, 2) != 0),
           5'($urandom), $urandom, ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
